core: RTL and testbench

//  8-bit single-cycle CPU datapath: 8x8-bit register bank, ALU, flag register and
//  8-bit instruction pointer with conditional branch unit. An external decoder supplies
//  pre-decoded control lines and the immediate byte each cycle; the core executes one instruction per rising CLK edge.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/core_alu.sv | 55 +++++
 rtl/core.sv | 125 ++++++++++++
 tb/tb_core.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the 8-bit core: ALU opcodes, branch conditions, write sources, flag bits.
// The optional external-data write path is enabled by defining CORE_EXT_DATA_EN.
package core_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_NOR = 4'b1011;

  // Low three opcode bits; bit 3 is ignored for these operations.
  localparam logic [2:0] OPL_XOR = 3'b001;
  localparam logic [2:0] OPL_AND = 3'b010;
  localparam logic [2:0] OPL_SHL = 3'b100;
  localparam logic [2:0] OPL_SHR = 3'b101;
  localparam logic [2:0] OPL_ROL = 3'b110;
  localparam logic [2:0] OPL_ROR = 3'b111;

  localparam logic [3:0] BR_ALWAYS = 4'b0111;
  localparam logic [3:0] BR_NEVER  = 4'b0000;
  localparam logic [3:0] BR_EQ     = 4'b1011;
  localparam logic [3:0] BR_NE     = 4'b0011;
  localparam logic [3:0] BR_CS     = 4'b1001;
  localparam logic [3:0] BR_CC     = 4'b0001;
  localparam logic [3:0] BR_MI     = 4'b1101;
  localparam logic [3:0] BR_PL     = 4'b0101;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_REG = 2'b01,
    SRC_IMM = 2'b10,
    SRC_EXT = 2'b11
  } src_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  function automatic logic [7:0] rotl8(input logic [7:0] a, input logic [2:0] s);
    logic [15:0] t;
    t = {a, a} << s;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] a, input logic [2:0] s);
    logic [15:0] t;
    t = {a, a} >> s;
    return t[7:0];
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational 8-bit ALU: result plus Z/C/N/V. Carry and overflow are only
// meaningful for ADD and SUB; every other operation reports them as zero.
module core_alu
  import core_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] result,
  output logic       z,
  output logic       c,
  output logic       n,
  output logic       v
);

  logic [8:0] sum;
  logic [8:0] diff;
  logic [2:0] sh;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    sh     = b[2:0];
    result = 8'h00;
    c      = 1'b0;
    v      = 1'b0;
    if (op == OP_ADD) begin
      result = sum[7:0];
      c      = sum[8];
      v      = (a[7] == b[7]) && (sum[7] != a[7]);
    end else if (op == OP_SUB) begin
      // Carry means "no borrow", i.e. A >= B unsigned.
      result = diff[7:0];
      c      = ~diff[8];
      v      = (a[7] != b[7]) && (diff[7] != a[7]);
    end else if (op == OP_OR) begin
      result = a | b;
    end else if (op == OP_NOR) begin
      result = ~(a | b);
    end else begin
      case (op[2:0])
        OPL_XOR: result = a ^ b;
        OPL_AND: result = a & b;
        OPL_SHL: result = a << sh;
        OPL_SHR: result = a >> sh;
        OPL_ROL: result = rotl8(a, sh);
        OPL_ROR: result = rotr8(a, sh);
        default: result = 8'h00;
      endcase
    end
    z = (result == 8'h00);
    n = result[7];
  end

endmodule

// File: rtl/core.sv
// Single-cycle 8-bit datapath: register bank, write mux, flags, instruction pointer
// and branch unit. Define CORE_EXT_DATA_EN to add the MEM_DATA write source.
module core
  import core_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
`ifdef CORE_EXT_DATA_EN
  input  logic [7:0] MEM_DATA,
`endif
  output logic [7:0] Addr,
  output logic [7:0] FLAGS,
  output logic [7:0] R0,
  output logic [7:0] R1,
  output logic [7:0] R2,
  output logic [7:0] R3,
  output logic [7:0] R4,
  output logic [7:0] R5,
  output logic [7:0] R6,
  output logic [7:0] R7,
  input  logic       MEM_INST,
  input  logic       ALU_INST,
  input  logic       JMP_INST,
  input  logic       MS1,
  input  logic       MS0,
  input  logic       IRS,
  input  logic       TS2,
  input  logic       TS1,
  input  logic       TS0,
  input  logic       AS2,
  input  logic       AS1,
  input  logic       AS0,
  input  logic       BS2,
  input  logic       BS1,
  input  logic       BS0,
  input  logic [3:0] OP,
  input  logic [7:0] IMM
);

  logic [7:0] regs [8];
  logic [2:0] ts, as, bs;
  logic [7:0] a_val, b_val, alu_res, wdata, ext_data;
  logic       alu_z, alu_c, alu_n, alu_v;
  logic       taken;

  assign ts    = {TS2, TS1, TS0};
  assign as    = {AS2, AS1, AS0};
  assign bs    = {BS2, BS1, BS0};
  assign a_val = regs[as];
  assign b_val = IRS ? IMM : regs[bs];

  core_alu u_alu (
    .a      (a_val),
    .b      (b_val),
    .op     (OP),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c),
    .n      (alu_n),
    .v      (alu_v)
  );

`ifdef CORE_EXT_DATA_EN
  assign ext_data = MEM_DATA;
`else
  assign ext_data = 8'h00;
`endif

  always_comb begin
    wdata = 8'h00;
    case (src_e'({MS1, MS0}))
      SRC_ALU: wdata = alu_res;
      SRC_REG: wdata = a_val;
      SRC_IMM: wdata = IMM;
      SRC_EXT: wdata = ext_data;
      default: wdata = 8'h00;
    endcase
  end

  // Conditions look at the flags registered before this edge.
  always_comb begin
    taken = 1'b0;
    if (JMP_INST) begin
      case (OP)
        BR_ALWAYS: taken = 1'b1;
        BR_NEVER:  taken = 1'b0;
        BR_EQ:     taken = FLAGS[FLAG_Z];
        BR_NE:     taken = ~FLAGS[FLAG_Z];
        BR_CS:     taken = FLAGS[FLAG_C];
        BR_CC:     taken = ~FLAGS[FLAG_C];
        BR_MI:     taken = FLAGS[FLAG_N];
        BR_PL:     taken = ~FLAGS[FLAG_N];
        default:   taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      FLAGS <= 8'h00;
      Addr  <= 8'h00;
    end else begin
      if (MEM_INST && !JMP_INST) regs[ts] <= wdata;
      if (ALU_INST && !JMP_INST) begin
        FLAGS         <= 8'h00;
        FLAGS[FLAG_Z] <= alu_z;
        FLAGS[FLAG_C] <= alu_c;
        FLAGS[FLAG_N] <= alu_n;
        FLAGS[FLAG_V] <= alu_v;
      end
      Addr <= taken ? (IMM + 8'd1) : (Addr + 8'd1);
    end
  end

  assign R0 = regs[0];
  assign R1 = regs[1];
  assign R2 = regs[2];
  assign R3 = regs[3];
  assign R4 = regs[4];
  assign R5 = regs[5];
  assign R6 = regs[6];
  assign R7 = regs[7];

endmodule

// File: tb/tb_core.sv
// Bench for core: a behavioural model predicts Addr, FLAGS and R0..R7 after each
// instruction; expectations are queued on issue and compared after the clock edge.
module tb_core;

  typedef struct packed {
    logic       mem;
    logic       alu;
    logic       jmp;
    logic [1:0] ms;
    logic       irs;
    logic [2:0] ts;
    logic [2:0] as;
    logic [2:0] bs;
    logic [3:0] op;
    logic [7:0] imm;
  } instr_t;

  logic       CLK, RST;
  logic [7:0] Addr, FLAGS, R0, R1, R2, R3, R4, R5, R6, R7;
  logic       MEM_INST, ALU_INST, JMP_INST, MS1, MS0, IRS;
  logic       TS2, TS1, TS0, AS2, AS1, AS0, BS2, BS1, BS0;
  logic [3:0] OP;
  logic [7:0] IMM;
`ifdef CORE_EXT_DATA_EN
  logic [7:0] MEM_DATA;
`endif

  logic [7:0] exp_q [$];
  logic [7:0] m_r [8];
  logic [7:0] m_flags, m_addr;
  int         total = 0;
  int         bad = 0;

  wire [7:0] obs [10];
  assign obs[0] = Addr;
  assign obs[1] = FLAGS;
  assign obs[2] = R0;
  assign obs[3] = R1;
  assign obs[4] = R2;
  assign obs[5] = R3;
  assign obs[6] = R4;
  assign obs[7] = R5;
  assign obs[8] = R6;
  assign obs[9] = R7;

  core dut (
    .CLK      (CLK),
    .RST      (RST),
`ifdef CORE_EXT_DATA_EN
    .MEM_DATA (MEM_DATA),
`endif
    .Addr     (Addr),
    .FLAGS    (FLAGS),
    .R0       (R0),
    .R1       (R1),
    .R2       (R2),
    .R3       (R3),
    .R4       (R4),
    .R5       (R5),
    .R6       (R6),
    .R7       (R7),
    .MEM_INST (MEM_INST),
    .ALU_INST (ALU_INST),
    .JMP_INST (JMP_INST),
    .MS1      (MS1),
    .MS0      (MS0),
    .IRS      (IRS),
    .TS2      (TS2),
    .TS1      (TS1),
    .TS0      (TS0),
    .AS2      (AS2),
    .AS1      (AS1),
    .AS0      (AS0),
    .BS2      (BS2),
    .BS1      (BS1),
    .BS0      (BS0),
    .OP       (OP),
    .IMM      (IMM)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic void ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic cf, output logic vf);
    int ai, bi, sa, sb, s, t;
    ai = int'(a);
    bi = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = int'(b[2:0]);
    cf = 1'b0;
    vf = 1'b0;
    t  = 0;
    casez (op)
      4'b0000: begin t = ai + bi; cf = (t > 255); vf = (sa + sb > 127) || (sa + sb < -128); end
      4'b1000: begin t = ai - bi; cf = (ai >= bi); vf = (sa - sb > 127) || (sa - sb < -128); end
      4'b?001: t = ai ^ bi;
      4'b?010: t = ai & bi;
      4'b0011: t = ai | bi;
      4'b1011: t = ~(ai | bi);
      4'b?100: t = ai << s;
      4'b?101: t = ai >> s;
      4'b?110: t = (ai << s) | (ai >> (8 - s));
      4'b?111: t = (ai >> s) | (ai << (8 - s));
      default: t = 0;
    endcase
    r = t[7:0];
  endfunction

  function automatic logic ref_branch(input logic [3:0] op, input logic [7:0] f);
    case (op)
      4'b0111: return 1'b1;
      4'b1011: return f[0];
      4'b0011: return !f[0];
      4'b1001: return f[1];
      4'b0001: return !f[1];
      4'b1101: return f[2];
      4'b0101: return !f[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic string obs_name(input int k);
    if (k == 0) return "Addr";
    if (k == 1) return "FLAGS";
    return $sformatf("R%0d", k - 2);
  endfunction

  function automatic instr_t mk(input logic mem, input logic alu, input logic jmp, input logic [1:0] ms,
                                input logic irs, input logic [2:0] ts, input logic [2:0] as,
                                input logic [2:0] bs, input logic [3:0] op, input logic [7:0] imm);
    instr_t x;
    x = {mem, alu, jmp, ms, irs, ts, as, bs, op, imm};
    return x;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_idle();
    {MEM_INST, ALU_INST, JMP_INST, MS1, MS0, IRS} = '0;
    {TS2, TS1, TS0, AS2, AS1, AS0, BS2, BS1, BS0} = '0;
    OP  = 4'h0;
    IMM = 8'h00;
`ifdef CORE_EXT_DATA_EN
    MEM_DATA = 8'h00;
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
    m_flags = 8'h00;
    m_addr  = 8'h00;
  endtask

  task automatic push_model();
    exp_q.push_back(m_addr);
    exp_q.push_back(m_flags);
    for (int i = 0; i < 8; i++) exp_q.push_back(m_r[i]);
  endtask

  // Called at a falling edge: drive, predict, push, then advance past the next rising edge.
  task automatic issue(input instr_t in);
    logic [7:0] a, b, res, wd, ext;
    logic       cf, vf, tk;
    ext = 8'h00;
`ifdef CORE_EXT_DATA_EN
    MEM_DATA = 8'($urandom_range(0, 255));
    ext = MEM_DATA;
`endif
    MEM_INST = in.mem; ALU_INST = in.alu; JMP_INST = in.jmp;
    {MS1, MS0} = in.ms; IRS = in.irs;
    {TS2, TS1, TS0} = in.ts; {AS2, AS1, AS0} = in.as; {BS2, BS1, BS0} = in.bs;
    OP = in.op; IMM = in.imm;

    a = m_r[in.as];
    b = in.irs ? in.imm : m_r[in.bs];
    ref_alu(in.op, a, b, res, cf, vf);
    case (in.ms)
      2'b00:   wd = res;
      2'b01:   wd = a;
      2'b10:   wd = in.imm;
      default: wd = ext;
    endcase
    tk = in.jmp && ref_branch(in.op, m_flags);
    if (!in.jmp && in.mem) m_r[in.ts] = wd;
    if (!in.jmp && in.alu) m_flags = {4'b0000, vf, res[7], cf, (res == 8'h00)};
    m_addr = tk ? in.imm + 8'd1 : m_addr + 8'd1;
    push_model();

    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] e;
    drive_idle();
    RST = 1'b0;
    #1 RST = 1'b1;
    #1;
    model_reset();
    push_model();
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      total++;
      if (obs[k] !== e) begin
        bad++;
        $display("FAIL reset %s: got %h want %h", obs_name(k), obs[k], e);
      end
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_mov_jmp();
    instr_t tbl [3];
    logic [7:0] e;
    tbl[0] = mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0111, 8'hFF);
    tbl[1] = mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 8'd5);
    tbl[2] = mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 3'd1, 3'd0, 3'd0, 4'b0000, 8'd7);
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i]);
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs[k] !== e) begin
          bad++;
          $display("FAIL mov_jmp step%0d %s: got %h want %h", i, obs_name(k), obs[k], e);
        end
      end
    end
    total++;
    if (R0 !== 8'd5 || R1 !== 8'd7 || Addr !== 8'd2) begin
      bad++;
      $display("FAIL mov_jmp final: got R0=%0d R1=%0d Addr=%0d want 5 7 2", R0, R1, Addr);
    end
  endtask

  task automatic test_math();
    instr_t tbl [3];
    logic [7:0] e;
    tbl[0] = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 3'd1, 4'b0000, 8'd0);
    tbl[1] = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd0, 3'd0, 3'd0, 4'b0000, 8'd9);
    tbl[2] = mk(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 3'd7, 3'd1, 3'd0, 4'b0000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i]);
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs[k] !== e) begin
          bad++;
          $display("FAIL math step%0d %s: got %h want %h", i, obs_name(k), obs[k], e);
        end
      end
    end
    total++;
    if (R0 !== 8'd21 || R7 !== 8'd7 || Addr !== 8'd5) begin
      bad++;
      $display("FAIL math final: got R0=%0d R7=%0d Addr=%0d want 21 7 5", R0, R7, Addr);
    end
  endtask

  task automatic test_cmp_branch();
    instr_t tbl [2];
    logic [7:0] e;
    tbl[0] = mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'd7, 3'd7, 3'd0, 4'b1000, 8'd7);
    tbl[1] = mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 4'b1011, 8'd63);
    for (int i = 0; i < 2; i++) begin
      issue(tbl[i]);
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs[k] !== e) begin
          bad++;
          $display("FAIL cmp_branch step%0d %s: got %h want %h", i, obs_name(k), obs[k], e);
        end
      end
    end
    total++;
    if (FLAGS !== 8'h03 || R7 !== 8'd7 || Addr !== 8'd64) begin
      bad++;
      $display("FAIL cmp_branch final: got FLAGS=%h R7=%0d Addr=%0d want 03 7 64", FLAGS, R7, Addr);
    end
  endtask

  task automatic test_shift();
    instr_t tbl [2];
    logic [7:0] e;
    tbl[0] = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 3'd6, 3'd0, 3'd0, 4'b0100, 8'd0);
    tbl[1] = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd5, 3'd0, 3'd0, 4'b0100, 8'd3);
    for (int i = 0; i < 2; i++) begin
      issue(tbl[i]);
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs[k] !== e) begin
          bad++;
          $display("FAIL shift step%0d %s: got %h want %h", i, obs_name(k), obs[k], e);
        end
      end
    end
    total++;
    if (R6 !== 8'hA0 || R5 !== 8'd168 || Addr !== 8'd66) begin
      bad++;
      $display("FAIL shift final: got R6=%h R5=%0d Addr=%0d want a0 168 66", R6, R5, Addr);
    end
  endtask

  task automatic test_carry_sign();
    instr_t tbl [6];
    logic [7:0] e;
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 3'd2, 3'd0, 3'd0, 4'b0000, 8'd200);
    tbl[1] = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd3, 3'd2, 3'd0, 4'b0000, 8'd100);
    tbl[2] = mk(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 3'd4, 3'd0, 3'd0, 4'b0000, 8'd3);
    tbl[3] = mk(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 3'd4, 3'd0, 4'b1000, 8'd5);
    tbl[4] = mk(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 3'd4, 3'd0, 4'b1000, 8'd254);
    tbl[5] = mk(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0011, 8'd10);
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i]);
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs[k] !== e) begin
          bad++;
          $display("FAIL carry_sign step%0d %s: got %h want %h", i, obs_name(k), obs[k], e);
        end
      end
      if (i == 1) begin
        total++;
        if (R3 !== 8'd44 || FLAGS !== 8'h02) begin
          bad++;
          $display("FAIL add_carry: got R3=%0d FLAGS=%h want 44 02", R3, FLAGS);
        end
      end
      if (i == 3) begin
        total++;
        if (R4 !== 8'd254 || FLAGS !== 8'h04) begin
          bad++;
          $display("FAIL sub_borrow: got R4=%0d FLAGS=%h want 254 04", R4, FLAGS);
        end
      end
    end
    total++;
    if (Addr !== 8'd72) begin
      bad++;
      $display("FAIL ne_not_taken: got Addr=%0d want 72", Addr);
    end
  endtask

  task automatic test_wrap();
    instr_t tbl [2];
    logic [7:0] e;
    tbl[0] = mk(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 3'd1, 3'd0, 3'd0, 4'b0111, 8'hFE);
    tbl[1] = mk(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 4'b0000, 8'h00);
    for (int i = 0; i < 2; i++) begin
      issue(tbl[i]);
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs[k] !== e) begin
          bad++;
          $display("FAIL wrap step%0d %s: got %h want %h", i, obs_name(k), obs[k], e);
        end
      end
      total++;
      if (Addr !== ((i == 0) ? 8'hFF : 8'h00)) begin
        bad++;
        $display("FAIL wrap addr step%0d: got %h want %h", i, Addr, (i == 0) ? 8'hFF : 8'h00);
      end
    end
  endtask

  task automatic test_back_to_back();
    instr_t x;
    logic [7:0] e;
    for (int i = 0; i < 300; i++) begin
      x = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)));
      issue(x);
      for (int k = 0; k < 10; k++) begin
        e = exp_q.pop_front();
        total++;
        if (obs[k] !== e) begin
          bad++;
          $display("FAIL random step%0d op=%b %s: got %h want %h", i, x.op, obs_name(k), obs[k], e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] e;
    issue(mk(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 3'd3, 3'd0, 3'd0, 4'b0011, 8'h5A));
    for (int k = 0; k < 10; k++) void'(exp_q.pop_front());
    #2 RST = 1'b1;
    #1;
    model_reset();
    push_model();
    for (int k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      total++;
      if (obs[k] !== e) begin
        bad++;
        $display("FAIL async_reset %s: got %h want %h", obs_name(k), obs[k], e);
      end
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mov_jmp();
    test_math();
    test_cmp_branch();
    test_shift();
    test_carry_sign();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
